// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH independent programmable clock dividers off the 50 MHz clock.
// Each channel emits a one-cycle tick and a square wave at clk / divisor.
// A written divisor is staged in pend and becomes active only at a period
// boundary (wrap or sync), so outputs never show a runt period.
// A divisor below 2 parks the channel with its outputs held low.
module clk_div_bank #(
  parameter int          NCH         = 5,
  parameter int          CNT_W       = 32,
  parameter int          CH_W        = 3,
  parameter int unsigned DEFAULT_DIV = 50000
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] pend     [NCH];
  logic [CNT_W-1:0] act      [NCH];
  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] cnt_next [NCH];
  logic [NCH-1:0]   run;
  logic [NCH-1:0]   wrap;

  // Per-channel run qualification, period-end detect and next count value.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    run  = '0;
    wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      run[i]      = en[i] && (act[i] >= CNT_W'(2));
      wrap[i]     = (cnt[i] == act[i] - CNT_W'(1));
      cnt_next[i] = (sync || wrap[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
  end

  // Divisor write port; writes to a channel number >= NCH match no channel and are dropped.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      // NOTE: this small register file is reset because the reset divisor is part of the
      // defined behaviour; a large data memory would normally be left unreset.
      for (int i = 0; i < NCH; i++) pend[i] <= DIV_RST;
    end else if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ch == CH_W'(i)) pend[i] <= wr_div;
      end
    end
  end

  // Channel counters, active divisor and registered outputs.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        act[i] <= DIV_RST;
        cnt[i] <= '0;
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!run[i]) begin
          // Idle or stopped: keep tracking pend so a valid divisor starts the channel.
          // NOTE: non-blocking assignments here mean act picks up the pre-write pend
          // when a write lands on the same edge.
          act[i]  <= pend[i];
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else begin
          cnt[i]  <= cnt_next[i];
          tick[i] <= wrap[i] && !sync;
          sq[i]   <= (cnt_next[i] < (act[i] >> 1));
          if (wrap[i] || sync) act[i] <= pend[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural per-channel model.
module tb_clk_div_bank;

  localparam int          NCH         = 5;
  localparam int          CNT_W       = 32;
  localparam int          CH_W        = 3;
  localparam int unsigned DEFAULT_DIV = 50000;

  logic             clk_50MHz = 1'b0;
  logic             rst       = 1'b0;
  logic [NCH-1:0]   en        = '0;
  logic             sync      = 1'b0;
  logic             wr_en     = 1'b0;
  logic [CH_W-1:0]  wr_ch     = '0;
  logic [CNT_W-1:0] wr_div    = '0;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: staged divisor, divisor in use, position in period.
  longint unsigned m_pend [NCH];
  longint unsigned m_act  [NCH];
  longint unsigned m_pos  [NCH];
  logic [NCH-1:0]  m_tick;
  logic [NCH-1:0]  m_sq;

  clk_div_bank #(
    .NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .en(en), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .tick(tick), .sq(sq)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = DEFAULT_DIV;
      m_act[i]  = DEFAULT_DIV;
      m_pos[i]  = 0;
    end
    m_tick = '0;
    m_sq   = '0;
  endfunction

  // One clock edge of the behavioural model, driven by the current inputs.
  function automatic void model_step();
    longint unsigned old_pend [NCH];
    for (int i = 0; i < NCH; i++) old_pend[i] = m_pend[i];
    if (wr_en && int'(wr_ch) < NCH) m_pend[int'(wr_ch)] = longint'(wr_div);
    for (int i = 0; i < NCH; i++) begin
      if (!en[i] || m_act[i] < 2) begin
        m_pos[i]  = 0;
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
        m_act[i]  = old_pend[i];
      end else begin
        bit end_of_period;
        longint unsigned half;
        end_of_period = (m_pos[i] + 1 == m_act[i]);
        half          = m_act[i] / 2;
        m_tick[i]     = end_of_period && !sync;
        m_pos[i]      = (sync || end_of_period) ? 0 : m_pos[i] + 1;
        m_sq[i]       = (m_pos[i] < half);
        if (sync || end_of_period) m_act[i] = old_pend[i];
      end
    end
  endfunction

  // Advance one clock, update the model, compare at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk_50MHz);
    if (!rst) model_reset(); else model_step();
    @(negedge clk_50MHz);
    check({tag, "_tick"}, 64'(tick), 64'(m_tick));
    check({tag, "_sq"},   64'(sq),   64'(m_sq));
  endtask

  task automatic write_div(input int ch, input int unsigned val, input string tag);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = CNT_W'(val);
    cycle(tag);
    wr_en  = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    int first;
    int t0;
    int t1;

    // Reset held with the clock running: outputs stay low.
    model_reset();
    run(4, "rst_hold");

    // Default divisor: first tick on channel 0 exactly DEFAULT_DIV edges after enable.
    rst = 1'b1;
    en  = 5'b00001;
    first = 0;
    for (int k = 1; k <= int'(DEFAULT_DIV) + 100; k++) begin
      cycle("dflt");
      if (tick[0] && first == 0) begin
        first = k;
        break;
      end
    end
    check("first_tick_edge", 64'(first), 64'(DEFAULT_DIV));
    run(10, "dflt_post");

    // Divisor 4 on channel 1: tick every 4 cycles, sq 1,1,0,0.
    write_div(1, 4, "wr1");
    en = 5'b00011;
    t0 = -1;
    for (int k = 0; k < 24; k++) begin
      cycle("div4");
      if (tick[1]) begin
        if (t0 >= 0) check("div4_period", 64'(k - t0), 64'd4);
        t0 = k;
      end
    end

    // Divisor 5 on channel 2, then 10 written mid-period.
    write_div(2, 5, "wr2");
    en = 5'b00111;
    run(7, "div5");
    write_div(2, 10, "wr2b");
    run(30, "div5to10");

    // Channels 0/1 at 6 and 9, reloaded through a one-cycle disable, then synced.
    write_div(0, 6, "wr0");
    write_div(1, 9, "wr1b");
    en = 5'b00100;
    cycle("reload");
    en = 5'b00111;
    run(13, "pre_sync");
    sync = 1'b1;
    cycle("sync");
    sync = 1'b0;
    check("sync_sq", 64'(sq[1:0]), 64'd3);
    t0 = 0;
    t1 = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle("post_sync");
      if (tick[0] && t0 == 0) t0 = k;
      if (tick[1] && t1 == 0) t1 = k;
    end
    check("sync_tick0", 64'(t0), 64'd6);
    check("sync_tick1", 64'(t1), 64'd9);

    // Divisor 1 stops channel 2 after its next wrap; 3 restarts it.
    write_div(2, 1, "wr_stop");
    run(25, "stopped");
    check("stopped_out", 64'({tick[2], sq[2]}), 64'd0);
    write_div(2, 3, "wr_restart");
    run(12, "restart");

    // Out-of-range channel write changes nothing.
    write_div(7, 2, "wr_bad");
    run(20, "after_bad");

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
      sync  = ($urandom_range(0, 39) == 0);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_ch = CH_W'($urandom_range(0, 7));
      wr_div = CNT_W'($urandom_range(0, 14));
      cycle("rand");
    end
    sync  = 1'b0;
    wr_en = 1'b0;

    // Asynchronous reset between edges right after a sync (sq[1] is high).
    write_div(1, 4, "wr_pre_rst");
    en = 5'b00000;
    cycle("pre_rst_idle");
    en = 5'b11111;
    run(5, "pre_rst_run");
    sync = 1'b1;
    cycle("pre_rst_sync");
    sync = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("async_tick", 64'(tick), 64'd0);
    check("async_sq",   64'(sq),   64'd0);
    model_reset();
    run(3, "rst_mid");

    // Release: every divisor is back at the default, so no ticks appear.
    rst = 1'b1;
    run(100, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
